// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - word-addressed memory responder with WAIT_CYCLES latency and one-cycle ready pulse.
// Optional feature: define MEM_OOR_ERR_EN to flag and suppress accesses at addresses >= DEPTH.
module memory_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [25:0] addr_i,
    input  logic [31:0] data_in_i,
    input  logic        read_i,
    input  logic        write_i,
    output logic [31:0] data_out_o,
    output logic        ready_o,
    output logic        err_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [25:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          wr_q, wr_d;
    logic          ready_q, err_q;
    logic [31:0]   data_out_q;
    logic [31:0]   mem_q [DEPTH];
    logic          do_op;
    logic          oor;
    logic [AW-1:0] idx;

    assign idx = addr_q[AW-1:0];

`ifdef MEM_OOR_ERR_EN
    localparam logic [25:0] DEPTH_W = 26'(DEPTH);
    assign oor = (addr_q >= DEPTH_W);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_q[25:AW];
    assign oor = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        do_op   = 1'b0;
        case (state_q)
            IDLE: begin
                // Both strobes high is an illegal request and is simply ignored.
                if (read_i ^ write_i) begin
                    addr_d  = addr_i;
                    data_d  = data_in_i;
                    wr_d    = write_i;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_op   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 26'd0;
            data_q     <= 32'd0;
            wr_q       <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            ready_q <= do_op;
            err_q   <= do_op & oor;
            if (do_op && !wr_q) begin
                data_out_q <= oor ? 32'd0 : mem_q[idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (do_op && wr_q && !oor) begin
            mem_q[idx] <= data_q;
        end
    end

    assign data_out_o = data_out_q;
    assign ready_o    = ready_q;
    assign err_o      = err_q;
endmodule
